// File: rtl/dcache_write_buffer.sv
// Line-granular write buffer between the data cache and slow data memory.
// Coalesces writebacks, forwards buffered lines to refill reads, drains the oldest entry when idle.
module dcache_write_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;

  state_t            state, state_next;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail, hit_idx;
  logic [PTR_W:0]    count;
  logic              hit;
  logic              rd_hit, rd_miss, rd_done;
  logic              wr_update, wr_push, drain_start, drain_done;

  // Entries hold distinct addresses, so at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == cache_addr) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    rd_done     = 1'b0;
    wr_update   = 1'b0;
    wr_push     = 1'b0;
    drain_start = 1'b0;
    drain_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cache_read) begin
          if (hit) begin
            rd_hit     = 1'b1;
            state_next = RESP;
          end else begin
            rd_miss    = 1'b1;
            state_next = MEM_RD;
          end
        end else if (cache_write) begin
          if (hit) begin
            wr_update  = 1'b1;
            state_next = RESP;
          end else if (count != FULL_COUNT) begin
            wr_push    = 1'b1;
            state_next = RESP;
          end else begin
            drain_start = 1'b1;
            state_next  = MEM_WR;
          end
        end else if (count != '0) begin
          drain_start = 1'b1;
          state_next  = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          rd_done    = 1'b1;
          state_next = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and FIFO bookkeeping; push and pop never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_rdata <= '0;
      cache_ready <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      valid_q     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      cache_ready <= (state_next == RESP);
      if (rd_hit)  cache_rdata <= data_q[hit_idx];
      if (rd_done) begin
        cache_rdata <= mem_rdata;
        mem_read    <= 1'b0;
      end
      if (rd_miss) begin
        mem_read <= 1'b1;
        mem_addr <= cache_addr;
      end
      if (wr_push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
        count         <= count + (PTR_W + 1)'(1);
      end
      if (drain_start) begin
        mem_write <= 1'b1;
        mem_addr  <= addr_q[head];
        mem_wdata <= data_q[head];
      end
      if (drain_done) begin
        mem_write     <= 1'b0;
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
        count         <= count - (PTR_W + 1)'(1);
      end
    end
  end

  // Line storage needs no reset: valid_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (wr_update) data_q[hit_idx] <= cache_wdata;
    if (wr_push) begin
      addr_q[tail] <= cache_addr;
      data_q[tail] <= cache_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Table-driven bench for dcache_write_buffer with a latency-programmable memory model
// and hand-written sequences for coalescing, full-buffer stall, slow miss and mid-drain reset.
module tb_dcache_write_buffer;

  logic         clk;
  logic         rst_n;
  logic         cache_read, cache_write;
  logic [27:0]  cache_addr;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  dcache_write_buffer #(.DEPTH(2), .ADDR_W(28), .LINE_W(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_ready (cache_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          wr_log[$];
  logic         mem_hold;
  int           mem_latency;
  bit           rdata_override;
  logic [127:0] override_value;
  int           reads_issued;
  int           ready_cyc;
  int           lat_cnt;

  // Memory model: pulses mem_ready after mem_latency+1 sampled cycles unless held off.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read && mem_write) begin
        errors++;
        $display("[TB] FAIL mem_exclusive: mem_read=%0b mem_write=%0b, required not both 1", mem_read, mem_write);
      end
      if (!rst_n) begin
        mem_ready = 1'b0;
        lat_cnt   = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        lat_cnt   = 0;
      end else if ((mem_read || mem_write) && !mem_hold) begin
        if (lat_cnt >= mem_latency) begin
          mem_ready = 1'b1;
          ready_cyc = cyc;
          mem_rdata = rdata_override ? override_value : {4{4'hC, mem_addr}};
          if (mem_write) wr_log.push_back('{mem_addr, mem_wdata});
          if (mem_read) reads_issued++;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, expected event did not occur", name);
  endtask

  task automatic idleInputs();
    cache_read  = 1'b0;
    cache_write = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
  endtask

  task automatic waitReady(input int limit, input string name, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cache_ready) done = 1'b1;
    end
    if (!done) timeoutFail({name, "_ready"});
  endtask

  // Cycles are counted from the edge at which the buffer, back in IDLE, samples the request.
  task automatic applyStimulus(input string name, input logic is_read, input logic [27:0] addr,
                               input logic [127:0] wdata, output int cycles, output logic [127:0] rdata);
    cache_read  = is_read;
    cache_write = !is_read;
    cache_addr  = addr;
    cache_wdata = wdata;
    if (cache_ready) begin
      @(posedge clk);
      #1;
    end
    waitReady(50, name, cycles);
    rdata = cache_rdata;
  endtask

  task automatic waitDrain(input int limit, input string name);
    int n;
    n = 0;
    while (!(dut.count == 0 && !mem_write) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) timeoutFail({name, "_drain"});
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    idleInputs();
    mem_hold       = 1'b0;
    mem_latency    = 0;
    rdata_override = 1'b0;
    override_value = '0;
    reads_issued   = 0;
    wr_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         is_read;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    int           exp_cycles;
    string        name;
  } vec_t;

  vec_t         vecs[10];
  int           n;
  logic [127:0] rd;

  initial begin
    vecs[0] = '{1'b0, 28'h0000010, {32{4'hA}}, 128'h0,               1, "wr_a"};
    vecs[1] = '{1'b1, 28'h0000010, 128'h0,     {32{4'hA}},           1, "rd_hit_a"};
    vecs[2] = '{1'b0, 28'h0000030, {32{4'h5}}, 128'h0,               1, "wr_b"};
    vecs[3] = '{1'b1, 28'h0000030, 128'h0,     {32{4'h5}},           1, "rd_hit_b"};
    vecs[4] = '{1'b0, 28'h0000010, {32{4'h1}}, 128'h0,               1, "wr_coalesce_a"};
    vecs[5] = '{1'b1, 28'h0000010, 128'h0,     {32{4'h1}},           1, "rd_hit_a_new"};
    vecs[6] = '{1'b1, 28'h0000020, 128'h0,     {4{32'hC0000020}},    2, "rd_miss_20"};
    vecs[7] = '{1'b0, 28'h0000040, {16{8'hD8}}, 128'h0,              3, "wr_full_c"};
    vecs[8] = '{1'b1, 28'h0000010, 128'h0,     {4{32'hC0000010}},    2, "rd_miss_drained_a"};
    vecs[9] = '{1'b1, 28'h0000040, 128'h0,     {16{8'hD8}},          1, "rd_hit_c"};

    rst_n = 1'b1;
    idleInputs();
    mem_hold       = 1'b0;
    mem_latency    = 0;
    rdata_override = 1'b0;
    override_value = '0;
    reads_issued   = 0;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cache_ready", 128'(cache_ready), 128'h0);
    checkOutput("rst_cache_rdata", cache_rdata, 128'h0);
    checkOutput("rst_mem_read",    128'(mem_read), 128'h0);
    checkOutput("rst_mem_write",   128'(mem_write), 128'h0);
    checkOutput("rst_mem_addr",    128'(mem_addr), 128'h0);
    checkOutput("rst_mem_wdata",   mem_wdata, 128'h0);
    checkOutput("rst_count",       128'(dut.count), 128'h0);
    checkOutput("rst_head",        128'(dut.head), 128'h0);
    checkOutput("rst_tail",        128'(dut.tail), 128'h0);
    checkOutput("rst_state",       128'(dut.state), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].name, vecs[i].is_read, vecs[i].addr, vecs[i].wdata, n, rd);
      checkOutput({vecs[i].name, "_cycles"}, 128'(n), 128'(vecs[i].exp_cycles));
      if (vecs[i].is_read) checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
    end
    idleInputs();
    waitDrain(100, "table");
    checkOutput("table_reads_issued", 128'(reads_issued), 128'd2);
    checkOutput("table_log_size", 128'(wr_log.size()), 128'd3);
    if (wr_log.size() == 3) begin
      checkOutput("table_log0_addr", 128'(wr_log[0].addr), 128'h10);
      checkOutput("table_log0_data", wr_log[0].data, {32{4'h1}});
      checkOutput("table_log1_addr", 128'(wr_log[1].addr), 128'h30);
      checkOutput("table_log1_data", wr_log[1].data, {32{4'h5}});
      checkOutput("table_log2_addr", 128'(wr_log[2].addr), 128'h40);
      checkOutput("table_log2_data", wr_log[2].data, {16{8'hD8}});
    end

    $display("[TB] write then idle drain");
    resetDut();
    mem_latency = 2;
    applyStimulus("drain_wr", 1'b0, 28'h0000010, {32{4'hA}}, n, rd);
    checkOutput("drain_wr_cycles", 128'(n), 128'd1);
    idleInputs();
    n = 0;
    while (!mem_write && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_start_delay", 128'(n), 128'd2);
    checkOutput("drain_mem_addr", 128'(mem_addr), 128'h10);
    checkOutput("drain_mem_wdata", mem_wdata, {32{4'hA}});
    waitDrain(50, "drain");
    checkOutput("drain_count", 128'(dut.count), 128'h0);
    checkOutput("drain_log_size", 128'(wr_log.size()), 128'd1);

    $display("[TB] coalescing with memory stalled");
    resetDut();
    mem_hold = 1'b1;
    applyStimulus("coal_d1", 1'b0, 28'h0000050, {32{4'h3}}, n, rd);
    checkOutput("coal_d1_cycles", 128'(n), 128'd1);
    applyStimulus("coal_d2", 1'b0, 28'h0000050, {32{4'h7}}, n, rd);
    checkOutput("coal_d2_cycles", 128'(n), 128'd1);
    idleInputs();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("coal_count", 128'(dut.count), 128'd1);
    checkOutput("coal_mem_write", 128'(mem_write), 128'd1);
    checkOutput("coal_mem_wdata", mem_wdata, {32{4'h7}});
    mem_hold = 1'b0;
    waitDrain(50, "coal");
    checkOutput("coal_log_size", 128'(wr_log.size()), 128'd1);
    if (wr_log.size() == 1) checkOutput("coal_log_data", wr_log[0].data, {32{4'h7}});

    $display("[TB] full buffer write stall");
    resetDut();
    mem_hold = 1'b1;
    applyStimulus("fill_a", 1'b0, 28'h0000060, {32{4'h6}}, n, rd);
    applyStimulus("fill_b", 1'b0, 28'h0000070, {32{4'h8}}, n, rd);
    checkOutput("fill_b_cycles", 128'(n), 128'd1);
    cache_write = 1'b1;
    cache_addr  = 28'h0000080;
    cache_wdata = {32{4'h9}};
    repeat (5) @(posedge clk);
    #1;
    checkOutput("fill_stall_ready", 128'(cache_ready), 128'h0);
    checkOutput("fill_stall_mem_write", 128'(mem_write), 128'd1);
    checkOutput("fill_stall_mem_addr", 128'(mem_addr), 128'h60);
    mem_hold = 1'b0;
    waitReady(20, "fill_c", n);
    checkOutput("fill_c_log_size", 128'(wr_log.size()), 128'd1);
    idleInputs();
    waitDrain(50, "fill");
    checkOutput("fill_log_size", 128'(wr_log.size()), 128'd3);
    if (wr_log.size() == 3) begin
      checkOutput("fill_order0", 128'(wr_log[0].addr), 128'h60);
      checkOutput("fill_order1", 128'(wr_log[1].addr), 128'h70);
      checkOutput("fill_order2", 128'(wr_log[2].addr), 128'h80);
      checkOutput("fill_order2_data", wr_log[2].data, {32{4'h9}});
    end

    $display("[TB] slow read miss");
    resetDut();
    mem_latency    = 5;
    rdata_override = 1'b1;
    override_value = 128'h12345678_9abcdef0_0fedcba9_87654321;
    applyStimulus("miss_slow", 1'b1, 28'h0000020, 128'h0, n, rd);
    checkOutput("miss_slow_rdata", rd, 128'h12345678_9abcdef0_0fedcba9_87654321);
    checkOutput("miss_slow_cycles", 128'(n), 128'd7);
    checkOutput("miss_slow_after_mem_ready", 128'(cyc - ready_cyc), 128'd1);
    checkOutput("miss_slow_reads", 128'(reads_issued), 128'd1);
    idleInputs();
    @(posedge clk);
    #1;
    checkOutput("miss_slow_ready_pulse", 128'(cache_ready), 128'h0);

    $display("[TB] reset during drain");
    resetDut();
    mem_hold = 1'b1;
    applyStimulus("rst_mid_wr", 1'b0, 28'h0000090, {32{4'hE}}, n, rd);
    idleInputs();
    n = 0;
    while (!mem_write && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mem_write) timeoutFail("rst_mid_mem_write");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_mem_write", 128'(mem_write), 128'h0);
    checkOutput("rst_mid_mem_addr", 128'(mem_addr), 128'h0);
    checkOutput("rst_mid_mem_wdata", mem_wdata, 128'h0);
    checkOutput("rst_mid_cache_ready", 128'(cache_ready), 128'h0);
    checkOutput("rst_mid_count", 128'(dut.count), 128'h0);
    checkOutput("rst_mid_state", 128'(dut.state), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
